// File: rtl/button_debouncer.sv
// Debounces a pre-synchronized push-button level and reports press/release edges,
// a single long-press event per hold, and a wrapping count of accepted presses.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync_in,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       long_press,
  output logic [7:0] press_count
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    PRESSED   = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [DW-1:0] deb_cnt_r, deb_cnt_s;
  logic [LW-1:0] hold_cnt_r, hold_cnt_s;
  logic          long_done_r, long_done_s;
  logic          level_s, press_s, release_s, long_s;
  logic [7:0]    count_s;

  // Next-state, counter and output-pulse decode
  always_comb begin
    state_s     = state_r;
    deb_cnt_s   = deb_cnt_r;
    hold_cnt_s  = hold_cnt_r;
    long_done_s = long_done_r;
    press_s     = 1'b0;
    release_s   = 1'b0;
    long_s      = 1'b0;
    count_s     = press_count;

    // The hold timer runs through WAIT_LOW so a release bounce does not restart it
    if ((state_r == PRESSED) || (state_r == WAIT_LOW)) begin
      if (hold_cnt_r == HOLD_MAX) begin
        if (!long_done_r) begin
          long_s      = 1'b1;
          long_done_s = 1'b1;
        end else begin
          long_s      = 1'b0;
        end
      end else begin
        hold_cnt_s = hold_cnt_r + LW'(1);
      end
    end else begin
      hold_cnt_s = hold_cnt_r;
    end

    case (state_r)
      IDLE: begin
        if (sync_in) begin
          state_s   = WAIT_HIGH;
          deb_cnt_s = '0;
        end else begin
          state_s   = IDLE;
        end
      end
      WAIT_HIGH: begin
        if (!sync_in) begin
          state_s = IDLE;
        end else if (deb_cnt_r == DEB_MAX) begin
          state_s     = PRESSED;
          hold_cnt_s  = '0;
          long_done_s = 1'b0;
          press_s     = 1'b1;
          count_s     = press_count + 8'd1;
        end else begin
          deb_cnt_s = deb_cnt_r + DW'(1);
        end
      end
      PRESSED: begin
        if (!sync_in) begin
          state_s   = WAIT_LOW;
          deb_cnt_s = '0;
        end else begin
          state_s   = PRESSED;
        end
      end
      WAIT_LOW: begin
        if (sync_in) begin
          state_s = PRESSED;
        end else if (deb_cnt_r == DEB_MAX) begin
          state_s    = IDLE;
          hold_cnt_s = '0;
          release_s  = 1'b1;
        end else begin
          deb_cnt_s = deb_cnt_r + DW'(1);
        end
      end
      default: begin
        state_s    = IDLE;
        deb_cnt_s  = '0;
        hold_cnt_s = '0;
      end
    endcase

    level_s = (state_s == PRESSED) || (state_s == WAIT_LOW);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      deb_cnt_r   <= '0;
      hold_cnt_r  <= '0;
      long_done_r <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      long_press  <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state_r     <= state_s;
      deb_cnt_r   <= deb_cnt_s;
      hold_cnt_r  <= hold_cnt_s;
      long_done_r <= long_done_s;
      btn_level   <= level_s;
      btn_press   <= press_s;
      btn_release <= release_s;
      long_press  <= long_s;
      press_count <= count_s;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus a random
// level stream compared against a run-length behavioural model.
module tb_button_debouncer;

  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync_in;
  logic       btn_level, btn_press, btn_release, long_press;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: level flips after DEB+1 consecutive samples that differ from it
  bit m_level;
  int m_run, m_age, m_count;
  bit e_press, e_release, e_long;

  button_debouncer #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .clk(clk), .rst(rst), .sync_in(sync_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .long_press(long_press), .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_level = 1'b0; m_run = 0; m_age = 0; m_count = 0;
    e_press = 1'b0; e_release = 1'b0; e_long = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sync_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input bit v);
    @(negedge clk);
    sync_in = v;
    @(posedge clk);
    e_press = 1'b0; e_release = 1'b0; e_long = 1'b0;
    if (m_level) begin
      m_age++;
      if (m_age == LONG) e_long = 1'b1;
    end
    if (v != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_level = v;
        m_run = 0;
        if (v) begin
          e_press = 1'b1;
          m_count = (m_count + 1) % 256;
          m_age = 0;
        end else begin
          e_release = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks += 5;
    if (btn_level !== 1'b0)   begin n_fail++; $display("FAIL reset_level: got %b want 0", btn_level); end
    if (btn_press !== 1'b0)   begin n_fail++; $display("FAIL reset_press: got %b want 0", btn_press); end
    if (btn_release !== 1'b0) begin n_fail++; $display("FAIL reset_release: got %b want 0", btn_release); end
    if (long_press !== 1'b0)  begin n_fail++; $display("FAIL reset_long: got %b want 0", long_press); end
    if (press_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", press_count); end
  endtask

  task automatic test_press();
    apply_reset();
    for (int i = 1; i <= DEB + 1; i++) begin
      step(1'b1);
      n_checks++;
      if (btn_press !== (i == DEB + 1)) begin
        n_fail++; $display("FAIL press_edge%0d: got %b want %b", i, btn_press, (i == DEB + 1));
      end
    end
    n_checks += 2;
    if (btn_level !== 1'b1)   begin n_fail++; $display("FAIL press_level: got %b want 1", btn_level); end
    if (press_count !== 8'd1) begin n_fail++; $display("FAIL press_count: got %0d want 1", press_count); end
    step(1'b1);
    n_checks++;
    if (btn_press !== 1'b0) begin n_fail++; $display("FAIL press_one_cycle: got %b want 0", btn_press); end
  endtask

  task automatic test_bounce();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(i < 3);
      n_checks += 2;
      if (btn_press !== 1'b0) begin n_fail++; $display("FAIL bounce_press%0d: got %b want 0", i, btn_press); end
      if (btn_level !== 1'b0) begin n_fail++; $display("FAIL bounce_level%0d: got %b want 0", i, btn_level); end
    end
    n_checks++;
    if (press_count !== 8'd0) begin n_fail++; $display("FAIL bounce_count: got %0d want 0", press_count); end
  endtask

  task automatic test_release_bounce();
    bit seq [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    repeat (DEB + 1) step(1'b1);
    for (int k = 0; k < 8; k++) begin
      step(seq[k]);
      n_checks += 3;
      if (btn_release !== (k == 7)) begin n_fail++; $display("FAIL relb_release%0d: got %b want %b", k, btn_release, (k == 7)); end
      if (btn_level !== (k != 7))   begin n_fail++; $display("FAIL relb_level%0d: got %b want %b", k, btn_level, (k != 7)); end
      if (btn_press !== 1'b0)       begin n_fail++; $display("FAIL relb_press%0d: got %b want 0", k, btn_press); end
    end
  endtask

  task automatic test_long();
    int pulses = 0;
    apply_reset();
    repeat (DEB + 1) step(1'b1);
    for (int c = 1; c <= 40; c++) begin
      step(1'b1);
      if (long_press === 1'b1) pulses++;
      n_checks++;
      if (long_press !== (c == LONG)) begin
        n_fail++; $display("FAIL long_cycle%0d: got %b want %b", c, long_press, (c == LONG));
      end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL long_count: got %0d want 1", pulses); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int p = 1; p <= 256; p++) begin
      repeat (DEB + 1) step(1'b1);
      n_checks++;
      if (press_count !== 8'(p % 256)) begin
        n_fail++; $display("FAIL wrap_count%0d: got %0d want %0d", p, press_count, p % 256);
      end
      repeat (DEB + 1) step(1'b0);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1'b1);
    step(1'b1);
    #2 rst = 1'b1;
    #1;
    n_checks += 2;
    if (btn_level !== 1'b0 || btn_press !== 1'b0 || btn_release !== 1'b0 || long_press !== 1'b0)
      begin n_fail++; $display("FAIL arst_wait_outs: got %b%b%b%b want 0000", btn_level, btn_press, btn_release, long_press); end
    if (press_count !== 8'd0) begin n_fail++; $display("FAIL arst_wait_count: got %0d want 0", press_count); end
    model_reset();
    @(negedge clk); sync_in = 1'b0; rst = 1'b0;
    repeat (DEB + 1) step(1'b1);
    n_checks++;
    if (btn_level !== 1'b1) begin n_fail++; $display("FAIL arst_pre_level: got %b want 1", btn_level); end
    step(1'b1);
    #2 rst = 1'b1;
    #1;
    n_checks += 2;
    if (btn_level !== 1'b0)   begin n_fail++; $display("FAIL arst_pressed_level: got %b want 0", btn_level); end
    if (press_count !== 8'd0) begin n_fail++; $display("FAIL arst_pressed_count: got %0d want 0", press_count); end
    model_reset();
    @(negedge clk); sync_in = 1'b0; rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      n_checks++;
      if (btn_press !== 1'b0 || btn_release !== 1'b0 || long_press !== 1'b0 || btn_level !== 1'b0)
        begin n_fail++; $display("FAIL arst_quiet%0d: got %b%b%b%b want 0000", i, btn_level, btn_press, btn_release, long_press); end
    end
  endtask

  task automatic test_random();
    int cyc = 0;
    apply_reset();
    while (cyc < 1500) begin
      bit v = 1'($urandom_range(0, 1));
      int len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        step(v);
        cyc++;
        n_checks++;
        if (btn_level !== m_level || btn_press !== e_press || btn_release !== e_release ||
            long_press !== e_long || press_count !== 8'(m_count)) begin
          n_fail++;
          $display("FAIL rand_cyc%0d: got lvl=%b prs=%b rel=%b lng=%b cnt=%0d want lvl=%b prs=%b rel=%b lng=%b cnt=%0d",
                   cyc, btn_level, btn_press, btn_release, long_press, press_count,
                   m_level, e_press, e_release, e_long, m_count);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sync_in = 1'b0;
    model_reset();
    test_reset();
    test_press();
    test_bounce();
    test_release_bounce();
    test_long();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable samples required to accept a level change (minimum 2).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 100000000, meaning hold duration in clk cycles that qualifies a long press (minimum 2).
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port sync_in  input  1  button level already synchronized into clk domain; no further synchronization in this block.
REQ-006 The block SHALL have port btn_level  output  1  debounced button level.
REQ-007 The block SHALL have port btn_press  output  1  one-cycle pulse on accepted 0->1 change.
REQ-008 The block SHALL have port btn_release  output  1  one-cycle pulse on accepted 1->0 change.
REQ-009 The block SHALL have port long_press  output  1  one-cycle pulse when hold reaches LONG_CYCLES.
REQ-010 The block SHALL have port press_count  output  8  count of accepted presses.

Function
REQ-011 The block SHALL implement a registered FSM with states IDLE (stable low), WAIT_HIGH, PRESSED (stable high), WAIT_LOW.
REQ-012 The block SHALL, in IDLE with sync_in=1, go to WAIT_HIGH and clear the debounce counter to 0; with sync_in=0, stay in IDLE.
REQ-013 The block SHALL, in WAIT_HIGH with sync_in=0, return to IDLE with no output pulse (bounce rejected).
REQ-014 The block SHALL, in WAIT_HIGH with sync_in=1, increment the debounce counter; when the counter equals DEBOUNCE_CYCLES-1 at that edge, go to PRESSED.
REQ-015 The block SHALL therefore accept a press after DEBOUNCE_CYCLES+1 consecutive sampled 1s (first sample taken in IDLE); btn_level and btn_press SHALL rise on that same edge.
REQ-016 The block SHALL, in PRESSED with sync_in=0, go to WAIT_LOW with the debounce counter cleared; the release path SHALL mirror REQ-013..015 with levels inverted.
REQ-017 The block SHALL, in WAIT_LOW with sync_in=1, return to PRESSED with no pulse and btn_level held at 1.
REQ-018 The block SHALL drive btn_level as 1 in PRESSED and WAIT_LOW, and 0 in IDLE and WAIT_HIGH.
REQ-019 The block SHALL assert btn_press and btn_release for exactly one cycle per accepted change; the two SHALL never be high in the same cycle.
REQ-020 The block SHALL clear a hold counter on entry to PRESSED from WAIT_HIGH, and increment it every cycle in PRESSED and WAIT_LOW.
REQ-021 The block SHALL pulse long_press for one cycle on the edge where the hold counter reaches LONG_CYCLES-1; it SHALL saturate there and fire at most once per press.
REQ-022 The block SHALL clear the hold counter on entry to IDLE; the hold counter SHALL NOT restart on a WAIT_LOW->PRESSED bounce.
REQ-023 The block SHALL increment press_count on the edge btn_press rises, wrapping 255->0; it SHALL NOT change on rejected bounces.
REQ-024 The block SHALL size counter widths with $clog2 of the respective parameter, and every comparison SHALL be exact-equality with no off-by-one slack.

Reset
REQ-025 The block SHALL, on rst=1, immediately (asynchronously) force IDLE, all counters to 0, and btn_level, btn_press, btn_release, long_press and press_count to 0.
REQ-026 The block SHALL, when reset occurs mid-debounce or mid-hold, abandon the operation with no pulse on the reset edge or after release.
REQ-027 The block SHALL, on the first edge after rst deasserts with sync_in=1, go to WAIT_HIGH and treat it as a new press candidate.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-028 The bench SHALL check: sync_in 0->1 held -> btn_press high one cycle on 5th sampled edge; btn_level=1; press_count=1.
REQ-029 The bench SHALL check: sync_in high 3 edges then low -> no btn_press, btn_level stays 0, press_count=0.
REQ-030 The bench SHALL check: from PRESSED, sync_in low 2 edges, high, then low 5 edges -> single btn_release only after the final run; btn_level stays 1 until then.
REQ-031 The bench SHALL check: hold 40 cycles after accept -> exactly one long_press, 16 cycles after the btn_press edge; none after.
REQ-032 The bench SHALL check: 256 accepted presses -> press_count wraps to 0 on the 256th.
REQ-033 The bench SHALL check: rst pulsed mid WAIT_HIGH and in PRESSED -> all outputs 0 without waiting for clk; no pulse afterwards while sync_in=0.
